// File: rtl/ascon_permutation_ctrl.sv
// Iterative ASCON permutation: one round (pc -> ps -> pl) per clock over the 320-bit state,
// with a start/done handshake and a round counter that always finishes at constant index 11.

package ascon_permutation_ctrl_pkg;
  localparam int unsigned WORD_W    = 64;
  localparam int unsigned NUM_WORDS = 5;

  // Word 0 is x0, word 4 is x4; bit 63 is the MSB of each word.
  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] type_state;
endpackage

// 64 parallel 5-bit ASCON sboxes; column i is {x0[i], x1[i], x2[i], x3[i], x4[i]} with x0 as MSB.
module substitution_layer
  import ascon_permutation_ctrl_pkg::*;
(
  input  type_state din,
  output type_state dout
);
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  for (genvar i = 0; i < int'(WORD_W); i++) begin : g_col
    logic [4:0] col_in;
    logic [4:0] col_out;
    assign col_in     = {din[0][i], din[1][i], din[2][i], din[3][i], din[4][i]};
    assign col_out    = SBOX[col_in];
    assign dout[0][i] = col_out[4];
    assign dout[1][i] = col_out[3];
    assign dout[2][i] = col_out[2];
    assign dout[3][i] = col_out[1];
    assign dout[4][i] = col_out[0];
  end
endmodule

module ascon_permutation_ctrl
  import ascon_permutation_ctrl_pkg::*;
#(
  parameter int unsigned MAX_ROUNDS = 12
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [3:0] rounds_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic       busy_o,
  output logic       done_o
);
  localparam int unsigned RC_W    = 4;
  localparam logic [RC_W-1:0] MAX_R   = RC_W'(MAX_ROUNDS);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(MAX_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t            fsm_q, fsm_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic [RC_W-1:0] rounds_n;
  logic [RC_W-1:0] rc_start;
  type_state       state_d;
  type_state       pc_state;
  type_state       ps_state;
  type_state       round_out;
  logic            busy_d;
  logic            done_d;

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Out-of-range round requests run the full permutation.
  always_comb begin
    rounds_n = rounds_i;
    if (rounds_i == '0 || rounds_i > MAX_R) rounds_n = MAX_R;
    rc_start = MAX_R - rounds_n;
  end

  // Constant addition into the low byte of x2.
  always_comb begin
    pc_state       = state_o;
    pc_state[2][7:0] = state_o[2][7:0] ^ {~rc_q, rc_q};
  end

  substitution_layer u_sbox (
    .din  (pc_state),
    .dout (ps_state)
  );

  // Linear diffusion per word.
  always_comb begin
    round_out[0] = ps_state[0] ^ ror(ps_state[0], 19) ^ ror(ps_state[0], 28);
    round_out[1] = ps_state[1] ^ ror(ps_state[1], 61) ^ ror(ps_state[1], 39);
    round_out[2] = ps_state[2] ^ ror(ps_state[2], 1)  ^ ror(ps_state[2], 6);
    round_out[3] = ps_state[3] ^ ror(ps_state[3], 10) ^ ror(ps_state[3], 17);
    round_out[4] = ps_state[4] ^ ror(ps_state[4], 7)  ^ ror(ps_state[4], 41);
  end

  always_comb begin
    fsm_d   = fsm_q;
    rc_d    = rc_q;
    state_d = state_o;
    case (fsm_q)
      IDLE: begin
        if (start_i) begin
          state_d = state_i;
          rc_d    = rc_start;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = round_out;
        if (rc_q == RC_LAST) fsm_d = DONE;
        else                 rc_d  = rc_q + RC_W'(1);
      end
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
    busy_d = (fsm_d == RUN);
    done_d = (fsm_d == DONE);
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      rc_q    <= '0;
      state_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      rc_q    <= rc_d;
      state_o <= state_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end
endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
// Self-checking bench: a job-schedule model predicts busy/done/state every cycle from the
// ASCON round equations (bitsliced sbox form), plus directed latency and literal checks.

module tb_ascon_permutation_ctrl;
  import ascon_permutation_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] rounds;
  type_state  state_in;
  type_state  state_out;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  ascon_permutation_ctrl #(.MAX_ROUNDS(12)) dut (
    .clock_i  (clk),
    .resetb_i (rst_n),
    .start_i  (start),
    .rounds_i (rounds),
    .state_i  (state_in),
    .state_o  (state_out),
    .busy_o   (busy),
    .done_o   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] m_ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [7:0] m_const(input int rc);
    return 8'(((15 - rc) << 4) | rc);
  endfunction

  function automatic type_state m_sbox(input type_state s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state r;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
    return r;
  endfunction

  function automatic type_state m_round(input type_state s, input int rc);
    type_state t;
    t = s;
    t[2] = t[2] ^ {56'd0, m_const(rc)};
    t = m_sbox(t);
    t[0] = t[0] ^ m_ror(t[0], 19) ^ m_ror(t[0], 28);
    t[1] = t[1] ^ m_ror(t[1], 61) ^ m_ror(t[1], 39);
    t[2] = t[2] ^ m_ror(t[2], 1)  ^ m_ror(t[2], 6);
    t[3] = t[3] ^ m_ror(t[3], 10) ^ m_ror(t[3], 17);
    t[4] = t[4] ^ m_ror(t[4], 7)  ^ m_ror(t[4], 41);
    return t;
  endfunction

  function automatic int m_clamp(input logic [3:0] r);
    return (r == 0 || r > 12) ? 12 : int'(r);
  endfunction

  function automatic type_state rnd_state();
    type_state s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  // One accepted job: edge index of acceptance, round count, and state after j rounds.
  int        edge_cnt = 0;
  bit        have_job = 0;
  int        job_k    = 0;
  int        job_n    = 0;
  type_state exp_arr [13];

  // Model update on each edge, then compare outputs 2 time units later.
  always @(posedge clk) begin
    bit        exp_busy;
    bit        exp_done;
    type_state exp_state;
    int        j;
    edge_cnt++;
    if (!rst_n) begin
      have_job = 0;
    end else if (start && (!have_job || edge_cnt >= job_k + job_n + 2)) begin
      have_job   = 1;
      job_k      = edge_cnt;
      job_n      = m_clamp(rounds);
      exp_arr[0] = state_in;
      for (int i = 1; i <= job_n; i++)
        exp_arr[i] = m_round(exp_arr[i-1], 12 - job_n + i - 1);
    end
    if (have_job) begin
      j         = edge_cnt - job_k;
      exp_busy  = (j < job_n);
      exp_done  = (j == job_n);
      exp_state = exp_arr[(j < job_n) ? j : job_n];
    end else begin
      exp_busy  = 0;
      exp_done  = 0;
      exp_state = '0;
    end
    #2;
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL busy @%0t: got %b expected %b", $time, busy, exp_busy);
    end
    checks++;
    if (done !== exp_done) begin
      errors++;
      $display("FAIL done @%0t: got %b expected %b", $time, done, exp_done);
    end
    checks++;
    if (state_out !== exp_state) begin
      errors++;
      $display("FAIL state @%0t: got %h expected %h", $time, state_out, exp_state);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Start a permutation from IDLE and measure edges from the accept edge to done.
  task automatic run_perm(input logic [3:0] r, input type_state s, input int exp_lat,
                          input string name);
    int  cnt;
    bit  seen;
    repeat (2) @(negedge clk);
    start    = 1'b1;
    rounds   = r;
    state_in = s;
    cnt  = 0;
    seen = 0;
    while (!seen && cnt < 40) begin
      @(posedge clk);
      cnt++;
      #2;
      start    = 1'b0;
      state_in = rnd_state();
      if (done) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no done within 40 edges", name);
    end else if (cnt != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, cnt, exp_lat);
    end
  endtask

  type_state init_s;
  type_state tmp;
  int        dcount;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rounds   = 4'd0;
    state_in = '0;

    // Model pins: sbox column 1 -> 0x0b, constants, single round on zero state.
    tmp = '0; tmp[4] = 64'd1;
    tmp = m_sbox(tmp);
    check_val("model_sbox_x0", tmp[0], 64'h0);
    check_val("model_sbox_x1", tmp[1], 64'h1);
    check_val("model_sbox_x2", tmp[2], 64'hFFFFFFFFFFFFFFFE);
    check_val("model_sbox_x4", tmp[4], 64'h1);
    check_val("model_const6", 64'(m_const(6)), 64'h96);
    check_val("model_const11", 64'(m_const(11)), 64'h4B);
    tmp = m_round('0, 11);
    check_val("model_round_x0", tmp[0], 64'h000964B00000004B);

    repeat (3) @(negedge clk);
    check_val("reset_state_x0", state_out[0], 64'h0);
    check_val("reset_busy", 64'(busy), 64'h0);
    check_val("reset_done", 64'(done), 64'h0);
    rst_n = 1'b1;

    init_s[0] = 64'h80400C0600000000;
    init_s[1] = 64'h0001020304050607;
    init_s[2] = 64'h08090A0B0C0D0E0F;
    init_s[3] = 64'h0001020304050607;
    init_s[4] = 64'h08090A0B0C0D0E0F;

    run_perm(4'd12, init_s, 13, "p12");
    run_perm(4'd6,  init_s, 7,  "p6");
    run_perm(4'd0,  init_s, 13, "r0");
    run_perm(4'd15, init_s, 13, "r15");
    run_perm(4'd13, rnd_state(), 13, "r13");
    run_perm(4'd1,  '0, 2, "p1_zero");
    check_val("p1_zero_x0", state_out[0], 64'h000964B00000004B);
    check_val("p1_zero_x4", state_out[4], 64'h0);

    // Reset at round 5 of 12 aborts the job.
    repeat (2) @(negedge clk);
    start = 1'b1; rounds = 4'd12; state_in = init_s;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("abort_state_x2", state_out[2], 64'h0);
    check_val("abort_busy", 64'(busy), 64'h0);
    dcount = 0;
    repeat (20) begin
      @(posedge clk); #2;
      if (done) dcount++;
    end
    check_val("abort_no_done", 64'(dcount), 64'h0);
    run_perm(4'd8, init_s, 9, "after_abort");

    // Start held high: one job every 10 edges.
    repeat (2) @(negedge clk);
    start = 1'b1; rounds = 4'd8; state_in = rnd_state();
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (done) dcount++;
    end
    check_val("held_start_dones", 64'(dcount), 64'h4);
    @(negedge clk);
    start = 1'b0;

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst_n    = ($urandom_range(0, 399) != 0);
      start    = ($urandom_range(0, 3) == 0);
      rounds   = 4'($urandom_range(0, 15));
      state_in = rnd_state();
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ascon_permutation_ctrl.md
Name: ascon_permutation_ctrl

Overview:
- Iterative ASCON permutation engine: sequences constant addition, substitution and linear diffusion rounds over the 320-bit state, one round per clock.
- Instantiates the existing 64-column substitution_layer and adds the round-constant and linear-diffusion logic around it, plus a round counter and a start/done handshake.
- Shared by the initialisation, absorb and finalisation phases of the upper-level ASCON mode FSM. That FSM programs the round count: 12 for pa, 6 or 8 for pb.

Parameters:
- MAX_ROUNDS, 12, number of round constants supported; fixes the counter range 0..11.

Ports:
- clock_i  input  1  system clock, rising edge.
- resetb_i  input  1  asynchronous active-low reset.
- start_i  input  1  request to run a permutation; sampled only in IDLE.
- rounds_i  input  4  number of rounds to run. Legal range 1..12; 0 and 13..15 are clamped to 12.
- state_i  input  type_state (5x64)  state to permute; captured on the accepted start edge.
- state_o  output  type_state (5x64)  registered working state; holds the final value after done.
- busy_o  output  1  high from the cycle after an accepted start until done_o.
- done_o  output  1  one-cycle pulse when the final state is available on state_o.

Behaviour:
- Reset (asynchronous, resetb_i=0):
  - FSM goes to IDLE.
  - state register cleared to all zeros; round counter cleared to 0.
  - busy_o=0, done_o=0.
  - A reset mid-permutation aborts the permutation immediately; no done_o is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - When start_i=1, latch state_i into the state register.
  - Load round counter rc = 12 - n, where n is the clamped value of rounds_i. Go to RUN.
  - When start_i=0, hold.
- RUN:
  - Each edge applies one round to the state register: state <= pl(ps(pc(state, rc))). Then rc increments.
  - When rc = 11 is applied, go to DONE.
- DONE:
  - done_o=1 for exactly this cycle; busy_o=0; state_o holds the result.
  - Next edge returns to IDLE.
  - start_i is ignored in DONE; a new start is accepted in the following IDLE cycle.
- pc (constant addition): x2[7:0] ^= {~rc[3:0], rc[3:0]}, i.e. ((15-rc)<<4)|rc. Constants for rc = 0..11: 0xF0, 0xE1, 0xD2, 0xC3, 0xB4, 0xA5, 0x96, 0x87, 0x78, 0x69, 0x5A, 0x4B. Words x0, x1, x3, x4 are unchanged.
- ps (substitution): the substitution_layer instance. Column i is {x0[i], x1[i], x2[i], x3[i], x4[i]}, x0 is the MSB of the 5-bit sbox input, and bit 63 is the MSB of each word.
- pl (linear diffusion), using rotate-right (ror):
  - x0 ^= ror19 ^ ror28
  - x1 ^= ror61 ^ ror39
  - x2 ^= ror1 ^ ror6
  - x3 ^= ror10 ^ ror17
  - x4 ^= ror7 ^ ror41
- Latency: start edge at cycle k → done_o high during cycle k+n+1. busy_o is high during cycles k+1..k+n.
- start_i while busy_o=1 or done_o=1 is ignored. state_i is not re-sampled.
- The counter never exceeds 11 and does not wrap. The RUN→DONE transition is decoded from rc = 11, not from a separate down-counter.
- state_o is a direct register output; no combinational path from state_i to state_o.

Test Plan:
- Reset mid-RUN: assert resetb_i=0 for 1 cycle at round 5 of 12 → state_o = 0, busy_o = 0, done_o stays 0, FSM in IDLE; the next start works normally.
- rounds_i=12, state_i = ASCON-128 init (x0=0x80400C0600000000, key=0x000102…0F, nonce=0x000102…0F) → done_o pulses 13 cycles after the start edge. state_o equals the C reference-model p12 output; the inner rc trace is 0..11.
- rounds_i=6, same state → done_o after 7 cycles; state_o equals reference p6 (rc 6..11); constants observed 0x96, 0x87, 0x78, 0x69, 0x5A, 0x4B.
- rounds_i=0 and rounds_i=15 → both behave exactly as 12 rounds (13-cycle latency, identical output).
- rounds_i=1, state_i all zero → done_o after 2 cycles. state_o equals reference single round with rc=11, i.e. constant 0x4B applied.
- start_i held high continuously with rounds_i=8 → back-to-back permutations every 10 cycles (start, 8 RUN, DONE, IDLE-accept). Starts pulsed during RUN/DONE produce no extra done_o.
